mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage directly downstream of the execute stage in the unpipelined MIPS core.
- Takes the ALU result as the effective address and operand 2 as store data.
- Runs a request/acknowledge transaction on the data-memory bus. Handles byte, halfword and word lanes, big-endian.
- Stalls the core until the access completes, then returns load data, sign- or zero-extended.

Parameters:
- TIMEOUT_CYCLES, 16: max cycles in ACCESS waiting for i_dm_ack before a bus error.
- CNT_W, 5: width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_memRead  in  1  current instruction is a load.
- i_memWrite  in  1  current instruction is a store.
- i_size  in  2  00 byte, 01 halfword, 10 word, 11 treated as word.
- i_signed  in  1  load sign-extends (lb/lh) when 1; zero-extends (lbu/lhu) when 0.
- i_addr  in  32  effective address (execute ALU result).
- i_wdata  in  32  store data (execute op2); low byte/half is used for sub-word stores.
- o_dm_req  out  1  bus request; registered.
- o_dm_we  out  1  1 write, 0 read; registered.
- o_dm_addr  out  32  word-aligned address ({i_addr[31:2],2'b00}); registered.
- o_dm_be  out  4  byte enables; bit3 = byte offset 0 (big-endian); registered.
- o_dm_wdata  out  32  lane-replicated store data; registered.
- i_dm_ack  in  1  bus accepted write / read data valid.
- i_dm_rdata  in  32  read word.
- o_rdata  out  32  extracted load data; registered.
- o_stall  out  1  hold PC and register file; combinational.
- o_misaligned  out  1  address-alignment fault; combinational.
- o_bus_err  out  1  timeout fault; registered, one-cycle pulse.

Behaviour:
- Reset (sync, i_rst=1 at edge):
  - state=IDLE, counter=0.
  - o_dm_req, o_dm_we, o_dm_be, o_dm_addr, o_dm_wdata, o_rdata, o_bus_err all 0.
  - Applies in any state, including mid-ACCESS. The request drops at the reset edge; a later ack is ignored.
- Alignment check:
  - Misaligned when halfword and i_addr[0]=1, or word and i_addr[1:0]!=0.
  - Misaligned in IDLE with a request: o_misaligned=1, no bus cycle, no stall, state stays IDLE.
- Write priority: i_memRead and i_memWrite both 1 means a write; the read is ignored.
- FSM IDLE:
  - Aligned request: load the bus registers, counter=0, go to ACCESS. o_stall=1 this cycle.
  - No request: o_stall=0.
- FSM ACCESS:
  - o_dm_req=1; bus outputs are held stable; o_stall=1.
  - i_dm_ack=1: drop req. On a read, capture o_rdata. Go to DONE.
  - Otherwise, counter+1. If counter reaches TIMEOUT_CYCLES-1 without ack: drop req, o_rdata=0, o_bus_err=1, go to DONE.
- FSM DONE:
  - o_stall=0, so the core retires the instruction on this edge; o_rdata is valid.
  - o_bus_err is high only in this cycle (timeout case); cleared on exit.
  - Unconditional return to IDLE. Request inputs are ignored in DONE, because the same instruction is still presented.
- Latency: minimum 3 cycles (IDLE, ACCESS with immediate ack, DONE); each ACCESS wait cycle adds 1.
- Byte enables by offset (byte lanes): off0→1000, off1→0100, off2→0010, off3→0001.
- Byte enables for halfword: off0→1100, off2→0011. Word → 1111.
- Store data: byte replicated to {b,b,b,b}; half replicated to {h,h}; word passed through.
- Load extraction: select the lane by offset using the same mapping, then extend to 32 bits per i_signed.

Decomposition:
- Shared core package holds:
  - size codes SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state encodings ST_IDLE/ST_ACCESS/ST_DONE.
- One combinational sub-module, mem_lane_align, does the lane work:
  - inputs size, offset, signed, wdata, rdata;
  - outputs be, replicated wdata, extracted rdata, misaligned.
- mem_access holds the FSM, timeout counter and registers.

Test Plan:
- Word store: addr=0x0000_1004, wdata=0xDEADBEEF, ack on 2nd ACCESS cycle → dm_addr=0x1004, be=1111, we=1, wdata=0xDEADBEEF; o_stall high for 3 cycles, low in DONE.
- Byte load, signed: addr=0x2003, rdata=0x1122_3380, i_signed=1 → be=0001, o_rdata=0xFFFF_FF80.
- Byte load, unsigned: same stimulus with i_signed=0 → o_rdata=0x0000_0080.
- Halfword store: addr=0x3002, wdata=0x0000_A55A → be=0011, dm_wdata=0xA55A_A55A.
- Misaligned load: word access at addr=0x4001 → o_misaligned=1 same cycle, o_dm_req never asserts, o_stall=0.
- Timeout: ack never asserted → req drops after 16 ACCESS cycles, o_bus_err=1 for one cycle, o_rdata=0.
- Mid-ACCESS reset: i_rst asserted while req high → next cycle req=0, state IDLE; a late ack is ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: size codes and FSM states.
package mem_access_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_DONE   = 2'd2
   } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: byte enables, store replication, load extraction
// and alignment checking for byte/halfword/word accesses.
module mem_lane_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  i_size,
   input  logic [1:0]  i_offset,
   input  logic        i_signed,
   input  logic [31:0] i_wdata,
   input  logic [31:0] i_rdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic [31:0] o_rdata,
   output logic        o_misaligned
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Offset 0 is the most significant byte of the bus word.
   always_comb begin
      case (i_offset)
         2'd0:    byte_lane = i_rdata[31:24];
         2'd1:    byte_lane = i_rdata[23:16];
         2'd2:    byte_lane = i_rdata[15:8];
         default: byte_lane = i_rdata[7:0];
      endcase
   end

   assign half_lane = i_offset[1] ? i_rdata[15:0] : i_rdata[31:16];

   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      o_be         = 4'b1111;
      o_wdata      = i_wdata;
      o_rdata      = i_rdata;
      o_misaligned = 1'b0;
      case (i_size)
         SZ_BYTE: begin
            o_be    = 4'b1000 >> i_offset;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = {{24{i_signed & byte_lane[7]}}, byte_lane};
         end
         SZ_HALF: begin
            o_be         = i_offset[1] ? 4'b0011 : 4'b1100;
            o_wdata      = {2{i_wdata[15:0]}};
            o_rdata      = {{16{i_signed & half_lane[15]}}, half_lane};
            o_misaligned = i_offset[0];
         end
         default: begin
            o_misaligned = |i_offset;
         end
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory stage: runs one req/ack bus transaction per load/store, stalls the
// core meanwhile, and times out to a bus error if no ack arrives.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_memRead,
   input  logic        i_memWrite,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic        o_dm_req,
   output logic        o_dm_we,
   output logic [31:0] o_dm_addr,
   output logic [3:0]  o_dm_be,
   output logic [31:0] o_dm_wdata,
   input  logic        i_dm_ack,
   input  logic [31:0] i_dm_rdata,
   output logic [31:0] o_rdata,
   output logic        o_stall,
   output logic        o_misaligned,
   output logic        o_bus_err
);

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [31:0]       addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              bus_err_q, bus_err_d;

   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata;
   logic [31:0]       lane_rdata;
   logic              lane_mis;
   logic              req_in;

   mem_lane_align u_lane (
      .i_size       (i_size),
      .i_offset     (i_addr[1:0]),
      .i_signed     (i_signed),
      .i_wdata      (i_wdata),
      .i_rdata      (i_dm_rdata),
      .o_be         (lane_be),
      .o_wdata      (lane_wdata),
      .o_rdata      (lane_rdata),
      .o_misaligned (lane_mis)
   );

   assign req_in = i_memRead | i_memWrite;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      req_d        = req_q;
      we_d         = we_q;
      addr_d       = addr_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      bus_err_d    = 1'b0;
      o_stall      = 1'b0;
      o_misaligned = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_in) begin
               if (lane_mis) begin
                  o_misaligned = 1'b1;
               end else begin
                  o_stall = 1'b1;
                  req_d   = 1'b1;
                  we_d    = i_memWrite;
                  addr_d  = {i_addr[31:2], 2'b00};
                  be_d    = lane_be;
                  wdata_d = lane_wdata;
                  cnt_d   = '0;
                  state_d = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            o_stall = 1'b1;
            // An ack on the final allowed cycle still wins over the timeout.
            if (i_dm_ack) begin
               req_d = 1'b0;
               if (!we_q) rdata_d = lane_rdata;
               state_d = ST_DONE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               req_d     = 1'b0;
               rdata_d   = '0;
               bus_err_d = 1'b1;
               state_d   = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the clock edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         be_q      <= be_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign o_dm_req   = req_q;
   assign o_dm_we    = we_q;
   assign o_dm_addr  = addr_q;
   assign o_dm_be    = be_q;
   assign o_dm_wdata = wdata_q;
   assign o_rdata    = rdata_q;
   assign o_bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed vector table, corner-case
// sequences (timeout, misalignment, mid-access reset) and random transactions.
module tb_mem_access;

   logic        clk;
   logic        i_rst;
   logic        i_memRead;
   logic        i_memWrite;
   logic [1:0]  i_size;
   logic        i_signed;
   logic [31:0] i_addr;
   logic [31:0] i_wdata;
   logic        o_dm_req;
   logic        o_dm_we;
   logic [31:0] o_dm_addr;
   logic [3:0]  o_dm_be;
   logic [31:0] o_dm_wdata;
   logic        i_dm_ack;
   logic [31:0] i_dm_rdata;
   logic [31:0] o_rdata;
   logic        o_stall;
   logic        o_misaligned;
   logic        o_bus_err;

   mem_access #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_memRead    (i_memRead),
      .i_memWrite   (i_memWrite),
      .i_size       (i_size),
      .i_signed     (i_signed),
      .i_addr       (i_addr),
      .i_wdata      (i_wdata),
      .o_dm_req     (o_dm_req),
      .o_dm_we      (o_dm_we),
      .o_dm_addr    (o_dm_addr),
      .o_dm_be      (o_dm_be),
      .o_dm_wdata   (o_dm_wdata),
      .i_dm_ack     (i_dm_ack),
      .i_dm_rdata   (i_dm_rdata),
      .o_rdata      (o_rdata),
      .o_stall      (o_stall),
      .o_misaligned (o_misaligned),
      .o_bus_err    (o_bus_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_rdata = '0;   // expected contents of the held load-data output

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [1:0]  sz;
      logic        sgn;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [7:0]  ack_wait;
      logic [3:0]  be;
      logic [31:0] ewd;
      logic [31:0] erd;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference model: lanes counted from the most significant byte.
   function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] off);
      int o = off;
      if (sz == 2'd0) return 4'(8 >> o);
      if (sz == 2'd1) return (o == 0) ? 4'hC : 4'h3;
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] w);
      if (sz == 2'd0) return (w & 32'hFF) * 32'h0101_0101;
      if (sz == 2'd1) return (w & 32'hFFFF) * 32'h0001_0001;
      return w;
   endfunction

   function automatic logic [31:0] m_rdata(input logic [1:0] sz, input logic [1:0] off,
                                           input logic sgn, input logic [31:0] r);
      longint v;
      int o = off;
      if (sz == 2'd0) begin
         v = (r >> (8 * (3 - o))) & 32'hFF;
         if (sgn && v >= 128) v = v - 256;
      end else if (sz == 2'd1) begin
         v = (r >> (8 * (2 - o))) & 32'hFFFF;
         if (sgn && v >= 32768) v = v - 65536;
      end else begin
         v = r;
      end
      return v[31:0];
   endfunction

   task automatic run_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input int ack_wait,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_rdata, input string tag);
      bit acked = 0;
      @(negedge clk);
      i_memRead  = rd;
      i_memWrite = wr;
      i_size     = sz;
      i_signed   = sgn;
      i_addr     = addr;
      i_wdata    = wdata;
      i_dm_rdata = rdata;
      i_dm_ack   = 1'b0;
      #1;
      check({tag, " idle stall"}, 32'(o_stall), 32'd1);
      check({tag, " idle misaligned"}, 32'(o_misaligned), 32'd0);
      for (int k = 0; k < 16 && !acked; k++) begin
         @(negedge clk);
         check({tag, " access req"}, 32'(o_dm_req), 32'd1);
         check({tag, " access stall"}, 32'(o_stall), 32'd1);
         check({tag, " addr"}, o_dm_addr, {addr[31:2], 2'b00});
         check({tag, " be"}, 32'(o_dm_be), 32'(e_be));
         if (k == 0) begin
            check({tag, " we"}, 32'(o_dm_we), 32'(wr));
            if (wr) check({tag, " bus wdata"}, o_dm_wdata, e_wdata);
         end
         if (k == ack_wait) begin
            i_dm_ack = 1'b1;
            acked    = 1;
         end
      end
      @(negedge clk);
      i_dm_ack = 1'b0;
      if (rd && !wr) exp_rdata = e_rdata;
      check({tag, " done stall"}, 32'(o_stall), 32'd0);
      check({tag, " done req"}, 32'(o_dm_req), 32'd0);
      check({tag, " done bus_err"}, 32'(o_bus_err), 32'd0);
      check({tag, " rdata"}, o_rdata, exp_rdata);
      // Request was still presented during DONE; it must not start a new access.
      @(negedge clk);
      check({tag, " no restart"}, 32'(o_dm_req), 32'd0);
      i_memRead  = 1'b0;
      i_memWrite = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      vecs[0] = '{1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_1004, 32'hDEAD_BEEF, 32'h0, 8'd1, 4'hF, 32'hDEAD_BEEF, 32'h0};
      vecs[1] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_2003, 32'h0, 32'h1122_3380, 8'd0, 4'h1, 32'h0, 32'hFFFF_FF80};
      vecs[2] = '{1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_2003, 32'h0, 32'h1122_3380, 8'd2, 4'h1, 32'h0, 32'h0000_0080};
      vecs[3] = '{1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_3002, 32'h0000_A55A, 32'h0, 8'd0, 4'h3, 32'hA55A_A55A, 32'h0};
      vecs[4] = '{1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_3000, 32'h0, 32'h8001_1234, 8'd1, 4'hC, 32'h0, 32'hFFFF_8001};
      vecs[5] = '{1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_3002, 32'h0, 32'h8001_F234, 8'd0, 4'h3, 32'h0, 32'h0000_F234};
      vecs[6] = '{1'b0, 1'b1, 2'b00, 1'b0, 32'h0000_5001, 32'h1234_56C3, 32'h0, 8'd3, 4'h4, 32'hC3C3_C3C3, 32'h0};
      vecs[7] = '{1'b1, 1'b1, 2'b11, 1'b0, 32'h0000_6000, 32'h0BAD_F00D, 32'h0, 8'd0, 4'hF, 32'h0BAD_F00D, 32'h0};
      vecs[8] = '{1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_7000, 32'h0, 32'h7F00_0000, 8'd0, 4'h8, 32'h0, 32'h0000_007F};
      vecs[9] = '{1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_8008, 32'h0, 32'hCAFE_BABE, 8'd15, 4'hF, 32'h0, 32'hCAFE_BABE};

      i_rst = 1'b1; i_memRead = 1'b0; i_memWrite = 1'b0; i_size = 2'b10; i_signed = 1'b0;
      i_addr = '0; i_wdata = '0; i_dm_ack = 1'b0; i_dm_rdata = '0;
      repeat (2) @(negedge clk);
      check("reset req", 32'(o_dm_req), 32'd0);
      check("reset we", 32'(o_dm_we), 32'd0);
      check("reset addr", o_dm_addr, 32'd0);
      check("reset be", 32'(o_dm_be), 32'd0);
      check("reset wdata", o_dm_wdata, 32'd0);
      check("reset rdata", o_rdata, 32'd0);
      check("reset bus_err", 32'(o_bus_err), 32'd0);
      check("reset stall", 32'(o_stall), 32'd0);
      i_rst = 1'b0;

      for (int i = 0; i < 10; i++)
         run_txn(vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                 vecs[i].rdata, int'(vecs[i].ack_wait), vecs[i].be, vecs[i].ewd, vecs[i].erd,
                 $sformatf("vec%0d", i));

      // Timeout: no ack ever; o_rdata currently holds 0xCAFEBABE.
      @(negedge clk);
      i_memRead = 1'b1; i_memWrite = 1'b0; i_size = 2'b10; i_addr = 32'h0000_9000; i_dm_ack = 1'b0;
      @(negedge clk);
      cnt = 0;
      while (o_dm_req === 1'b1 && cnt < 40) begin
         cnt++;
         @(negedge clk);
      end
      check("timeout req cycles", 32'(cnt), 32'd16);
      exp_rdata = '0;
      check("timeout bus_err", 32'(o_bus_err), 32'd1);
      check("timeout rdata", o_rdata, exp_rdata);
      check("timeout done stall", 32'(o_stall), 32'd0);
      @(negedge clk);
      check("timeout bus_err clears", 32'(o_bus_err), 32'd0);
      check("timeout no restart", 32'(o_dm_req), 32'd0);
      i_memRead = 1'b0;

      // Misaligned word load and halfword store: flagged, no bus cycle, no stall.
      @(negedge clk);
      i_memRead = 1'b1; i_size = 2'b10; i_addr = 32'h0000_4001;
      #1;
      check("misaligned word flag", 32'(o_misaligned), 32'd1);
      check("misaligned word stall", 32'(o_stall), 32'd0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("misaligned no req", 32'(o_dm_req), 32'd0);
      end
      i_memRead = 1'b0; i_memWrite = 1'b1; i_size = 2'b01; i_addr = 32'h0000_4003;
      #1;
      check("misaligned half flag", 32'(o_misaligned), 32'd1);
      @(negedge clk);
      check("misaligned half no req", 32'(o_dm_req), 32'd0);
      i_memWrite = 1'b0;

      // Mid-ACCESS reset: load something first so the cleared o_rdata is visible.
      run_txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_A004, 32'h0, 32'h1122_3380, 0,
              4'hF, 32'h0, 32'h1122_3380, "prereset");
      @(negedge clk);
      i_memRead = 1'b1; i_size = 2'b10; i_addr = 32'h0000_A000; i_dm_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      check("midreset req before", 32'(o_dm_req), 32'd1);
      i_rst = 1'b1; i_memRead = 1'b0;
      @(negedge clk);
      i_rst = 1'b0;
      exp_rdata = '0;
      check("midreset req", 32'(o_dm_req), 32'd0);
      check("midreset stall", 32'(o_stall), 32'd0);
      check("midreset rdata", o_rdata, exp_rdata);
      check("midreset be", 32'(o_dm_be), 32'd0);
      i_dm_ack = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("late ack req", 32'(o_dm_req), 32'd0);
         check("late ack rdata", o_rdata, exp_rdata);
      end
      i_dm_ack = 1'b0;

      // Random aligned transactions against the model.
      for (int i = 0; i < 40; i++) begin
         logic [1:0]  sz;
         logic [31:0] addr;
         logic        rd, wr, sgn;
         logic [31:0] wd, rdv;
         int          sel;
         sel  = int'($urandom % 3);
         rd   = (sel != 1);
         wr   = (sel != 0);
         sz   = 2'($urandom % 4);
         sgn  = 1'($urandom % 2);
         addr = $urandom;
         if (sz == 2'd1) addr[0] = 1'b0;
         if (sz[1]) addr[1:0] = 2'b00;
         wd   = $urandom;
         rdv  = $urandom;
         run_txn(rd, wr, sz, sgn, addr, wd, rdv, int'($urandom % 5),
                 m_be(sz, addr[1:0]), m_wdata(sz, wd), m_rdata(sz, addr[1:0], sgn, rdv),
                 $sformatf("rand%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
